// File: rtl/sad_load_ctrl.sv
// SAD subsystem sequencer: streams host words into SRAM A/B port-B, starts the core, returns its result.
// Optional watchdog on the WAIT state is built when SAD_TIMEOUT_EN is defined.
module sad_load_ctrl #(
  parameter int WORDS   = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] In_Data,
  input  logic        In_Valid,
  output logic        In_Ready,
  output logic [31:0] Res_Data,
  output logic        Res_Err,
  output logic        Res_Valid,
  input  logic        Res_Ready,
  output logic [31:0] MA_di31,
  output logic [31:0] MB_di31,
  output logic [5:0]  MA_Addr6,
  output logic [5:0]  MB_Addr6,
  output logic        MA_enb,
  output logic        MB_enb,
  output logic        MA_web,
  output logic        MB_web,
  output logic        Rst_M,
  output logic        Rst_Core,
  output logic        Go_t,
  input  logic        Done_t,
  input  logic [31:0] SAD_Out_t,
  output logic        Busy
);

  localparam int DATA_W = 32;
  localparam logic [5:0] LAST = 6'(WORDS - 1);

  if (WORDS < 1 || WORDS > 64 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("sad_load_ctrl: WORDS must be 1..64 and TIMEOUT 1..65535");
  end

  typedef enum logic [2:0] {
    INIT,
    LOAD_A,
    LOAD_B,
    GO,
    WAIT,
    RESULT
  } state_t;

  state_t              state, state_d;
  logic [5:0]          cnt, cnt_d;
  logic                init_done, init_done_d;
  logic                hs;

  logic                wr_a_vld_p1, wr_a_vld_d;
  logic                wr_b_vld_p1, wr_b_vld_d;
  logic [5:0]          ma_addr_p1, ma_addr_d;
  logic [5:0]          mb_addr_p1, mb_addr_d;
  logic [DATA_W-1:0]   ma_di_p1, ma_di_d;
  logic [DATA_W-1:0]   mb_di_p1, mb_di_d;

  logic                go_q, go_d;
  logic                rst_m_q, rst_m_d;
  logic                rst_core_q, rst_core_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
`ifdef SAD_TIMEOUT_EN
  logic                res_err_q, res_err_d;
  logic [15:0]         wd_q, wd_d;
`endif

  assign In_Ready = (state == LOAD_A) || (state == LOAD_B);
  assign hs       = In_Valid && In_Ready;
  assign Busy     = !((state == LOAD_A) && (cnt == 6'd0));

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    init_done_d = init_done;
    wr_a_vld_d  = 1'b0;
    wr_b_vld_d  = 1'b0;
    ma_addr_d   = ma_addr_p1;
    mb_addr_d   = mb_addr_p1;
    ma_di_d     = ma_di_p1;
    mb_di_d     = mb_di_p1;
    go_d        = 1'b0;
    rst_m_d     = 1'b0;
    rst_core_d  = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
`ifdef SAD_TIMEOUT_EN
    res_err_d   = res_err_q;
    wd_d        = wd_q;
`endif

    case (state)
      INIT: begin
        // Sub-block resets span the reset-release cycle plus one more.
        if (init_done) begin
          state_d = LOAD_A;
          cnt_d   = 6'd0;
        end else begin
          init_done_d = 1'b1;
          rst_m_d     = 1'b1;
          rst_core_d  = 1'b1;
        end
      end

      LOAD_A, LOAD_B: begin
        if (hs) begin
          if (state == LOAD_A) begin
            wr_a_vld_d = 1'b1;
            ma_addr_d  = cnt;
            ma_di_d    = In_Data;
          end else begin
            wr_b_vld_d = 1'b1;
            mb_addr_d  = cnt;
            mb_di_d    = In_Data;
          end
          if (cnt == LAST) begin
            cnt_d   = 6'd0;
            state_d = (state == LOAD_A) ? LOAD_B : GO;
          end else begin
            cnt_d = cnt + 6'd1;
          end
        end
      end

      GO: begin
        go_d    = 1'b1;
        state_d = WAIT;
`ifdef SAD_TIMEOUT_EN
        wd_d    = 16'd0;
`endif
      end

      WAIT: begin
        // A completion in the same cycle as watchdog expiry takes precedence.
        if (Done_t) begin
          res_data_d  = SAD_Out_t;
          res_valid_d = 1'b1;
          state_d     = RESULT;
`ifdef SAD_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
        end
`ifdef SAD_TIMEOUT_EN
        else if (wd_q == 16'(TIMEOUT - 1)) begin
          res_data_d  = 32'hFFFF_FFFF;
          res_err_d   = 1'b1;
          res_valid_d = 1'b1;
          rst_core_d  = 1'b1;
          state_d     = RESULT;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end

      RESULT: begin
        if (Res_Ready) begin
          res_valid_d = 1'b0;
          state_d     = LOAD_A;
        end
      end

      default: state_d = INIT;
    endcase
  end

  // stage p0 -> p1: state, load handshake to SRAM write, result capture
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= INIT;
      cnt         <= 6'd0;
      init_done   <= 1'b0;
      wr_a_vld_p1 <= 1'b0;
      wr_b_vld_p1 <= 1'b0;
      ma_addr_p1  <= 6'd0;
      mb_addr_p1  <= 6'd0;
      ma_di_p1    <= '0;
      mb_di_p1    <= '0;
      go_q        <= 1'b0;
      rst_m_q     <= 1'b1;
      rst_core_q  <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
`ifdef SAD_TIMEOUT_EN
      res_err_q   <= 1'b0;
      wd_q        <= 16'd0;
`endif
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      init_done   <= init_done_d;
      wr_a_vld_p1 <= wr_a_vld_d;
      wr_b_vld_p1 <= wr_b_vld_d;
      ma_addr_p1  <= ma_addr_d;
      mb_addr_p1  <= mb_addr_d;
      ma_di_p1    <= ma_di_d;
      mb_di_p1    <= mb_di_d;
      go_q        <= go_d;
      rst_m_q     <= rst_m_d;
      rst_core_q  <= rst_core_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
`ifdef SAD_TIMEOUT_EN
      res_err_q   <= res_err_d;
      wd_q        <= wd_d;
`endif
    end
  end

  assign MA_enb    = wr_a_vld_p1;
  assign MA_web    = wr_a_vld_p1;
  assign MB_enb    = wr_b_vld_p1;
  assign MB_web    = wr_b_vld_p1;
  assign MA_Addr6  = ma_addr_p1;
  assign MB_Addr6  = mb_addr_p1;
  assign MA_di31   = ma_di_p1;
  assign MB_di31   = mb_di_p1;
  assign Go_t      = go_q;
  assign Rst_M     = rst_m_q;
  assign Rst_Core  = rst_core_q;
  assign Res_Valid = res_valid_q;
  assign Res_Data  = res_data_q;
`ifdef SAD_TIMEOUT_EN
  assign Res_Err   = res_err_q;
`else
  assign Res_Err   = 1'b0;
`endif

endmodule

// File: tb/tb_sad_load_ctrl.sv
// Scoreboard bench for sad_load_ctrl: randomized loads, result handshakes, reset recovery.
// The SAD_TIMEOUT_EN section runs only when the design is built with that macro.
module tb_sad_load_ctrl;
  localparam int WORDS     = 64;
  localparam int TIMEOUT_T = 10;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [31:0] In_Data = '0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [31:0] Res_Data;
  logic        Res_Err;
  logic        Res_Valid;
  logic        Res_Ready = 1'b0;
  logic [31:0] MA_di31, MB_di31;
  logic [5:0]  MA_Addr6, MB_Addr6;
  logic        MA_enb, MB_enb, MA_web, MB_web;
  logic        Rst_M, Rst_Core, Go_t;
  logic        Done_t = 1'b0;
  logic [31:0] SAD_Out_t = '0;
  logic        Busy;

  sad_load_ctrl #(.WORDS(WORDS), .TIMEOUT(TIMEOUT_T)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Res_Data(Res_Data), .Res_Err(Res_Err), .Res_Valid(Res_Valid), .Res_Ready(Res_Ready),
    .MA_di31(MA_di31), .MB_di31(MB_di31), .MA_Addr6(MA_Addr6), .MB_Addr6(MB_Addr6),
    .MA_enb(MA_enb), .MB_enb(MB_enb), .MA_web(MA_web), .MB_web(MB_web),
    .Rst_M(Rst_M), .Rst_Core(Rst_Core), .Go_t(Go_t), .Done_t(Done_t),
    .SAD_Out_t(SAD_Out_t), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct { bit mem_b; logic [5:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [31:0] data; logic err; } res_t;

  wr_t  wq[$];
  res_t rq[$];
  int   errors = 0, checks = 0, cyc = 0;
  int   load_idx = 0, go_due = -1, valid_due = -1, ir_due = -1, rst_run = 0;
  bit   in_wait = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s at cycle %0d", name, what, cyc);
  endtask

  // Monitor: everything sampled mid-cycle, away from the active edge.
  always @(negedge Clk) begin
    wr_t e;
    if (!Rst_n) begin
      check("reset_ctl", {In_Ready, Res_Valid, Res_Err, MA_enb, MB_enb, MA_web, MB_web, Go_t}, 0);
      check("reset_rst", {Rst_M, Rst_Core, Busy}, 3'b111);
      check("reset_ma", {MA_Addr6, MA_di31}, 0);
      check("reset_mb", {MB_Addr6, MB_di31}, 0);
      check("reset_res", Res_Data, 0);
      wq.delete();
      rq.delete();
      load_idx = 0; go_due = -1; valid_due = -1; ir_due = -1; rst_run = 0; in_wait = 0;
    end else begin
      if (Rst_M) rst_run++;
      else if (rst_run > 0) begin
        check("init_len", rst_run, 2);
        check("init_ready", {In_Ready, Rst_Core}, 2'b10);
        check("init_quiet", {MA_enb, MB_enb, Go_t}, 0);
        rst_run = 0;
      end
      check("busy", Busy, !(In_Ready && load_idx == 0));

      if (MA_enb || MB_enb) begin
        if (wq.size() == 0) flag("wr_unexpected", "write with no pending handshake");
        else begin
          e = wq.pop_front();
          check("wr_port", {MA_enb, MA_web, MB_enb, MB_web}, e.mem_b ? 4'b0011 : 4'b1100);
          check("wr_addr", e.mem_b ? MB_Addr6 : MA_Addr6, e.addr);
          check("wr_data", e.mem_b ? MB_di31 : MA_di31, e.data);
          check("wr_cycle", cyc, e.cyc);
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        void'(wq.pop_front());
        flag("wr_missing", "expected SRAM write did not occur");
      end

      if (In_Valid && In_Ready) begin
        wq.push_back('{load_idx >= WORDS, 6'(load_idx % WORDS), In_Data, cyc + 1});
        load_idx++;
        if (load_idx == 2 * WORDS) begin
          load_idx = 0;
          go_due = cyc + 2;
        end
      end

      if (Go_t || cyc == go_due) check("go_pulse", {Go_t, cyc == go_due}, 2'b11);
      if (Go_t) in_wait = 1;
      if (Done_t && in_wait) begin
        valid_due = cyc + 1;
        in_wait = 0;
      end
      if (cyc == valid_due) check("res_latency", Res_Valid, 1);
      if (cyc == ir_due) check("ready_after_res", {In_Ready, Res_Valid}, 2'b10);

      if (Res_Valid) begin
        in_wait = 0;
        if (rq.size() == 0) flag("res_unexpected", "result with no expected entry");
        else begin
          check("res_data", Res_Data, rq[0].data);
          check("res_err", Res_Err, rq[0].err);
          if (Res_Ready) begin
            void'(rq.pop_front());
            ir_due = cyc + 1;
          end
        end
      end
    end
  end

  task automatic load_words(input int n, input int pct, input bit seq);
    int k = 0;
    int guard = 0;
    while (k < n && guard < n * 100 + 100) begin
      @(posedge Clk); #1;
      In_Valid = ($urandom_range(0, 99) < pct);
      In_Data  = seq ? 32'(k) : $urandom;
      @(negedge Clk);
      if (In_Valid && In_Ready) k++;
      guard++;
    end
    @(posedge Clk); #1;
    In_Valid = 1'b0;
    check("load_count", k, n);
  endtask

  task automatic wait_go(output int g);
    int n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!Go_t && n < 20);
    g = cyc;
    if (!Go_t) flag("go_timeout", "Go_t never rose");
  endtask

  task automatic finish_result(input int hold);
    int n = 0;
    while (!Res_Valid && n < TIMEOUT_T + 100) begin
      @(negedge Clk);
      n++;
    end
    if (!Res_Valid) flag("res_timeout", "Res_Valid never rose");
    repeat (hold) @(posedge Clk);
    @(posedge Clk); #1;
    Res_Ready = 1'b1;
    @(posedge Clk); #1;
    Res_Ready = 1'b0;
  endtask

  task automatic run_txn(input int pct, input bit seq, input int hold,
                         input logic [31:0] sad, input bit early_ready);
    int g;
    load_words(2 * WORDS, pct, seq);
    wait_go(g);
    if (early_ready) begin
      @(posedge Clk); #1;
      Res_Ready = 1'b1;
      @(posedge Clk); #1;
      Res_Ready = 1'b0;
    end
    repeat ($urandom_range(0, 4)) @(posedge Clk);
    @(posedge Clk); #1;
    Done_t = 1'b1;
    SAD_Out_t = sad;
    rq.push_back('{sad, 1'b0});
    @(posedge Clk); #1;
    Done_t = 1'b0;
    SAD_Out_t = $urandom;
    finish_result(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int g;
    int n;
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;
    repeat (4) @(posedge Clk);

    // A completion pulse while idle must not produce a result.
    #1 Done_t = 1'b1;
    SAD_Out_t = 32'hDEAD_BEEF;
    @(posedge Clk); #1;
    Done_t = 1'b0;
    repeat (3) @(posedge Clk);

    run_txn(100, 1'b1, 5, 32'h0000_1A2B, 1'b0);
    run_txn(50, 1'b0, 0, $urandom, 1'b1);
    run_txn(70, 1'b0, 2, $urandom, 1'b0);

    load_words(40, 100, 1'b1);
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    repeat (3) @(posedge Clk);
    run_txn(100, 1'b1, 1, $urandom, 1'b0);
    run_txn(30, 1'b0, 3, $urandom, 1'b0);

`ifdef SAD_TIMEOUT_EN
    load_words(2 * WORDS, 100, 1'b0);
    wait_go(g);
    rq.push_back('{32'hFFFF_FFFF, 1'b1});
    n = 0;
    while (!Res_Valid && n < TIMEOUT_T + 20) begin
      @(negedge Clk);
      n++;
    end
    check("to_latency", cyc - g, TIMEOUT_T);
    check("to_rst_core", Rst_Core, 1);
    @(negedge Clk);
    check("to_rst_core_end", Rst_Core, 0);
    @(posedge Clk); #1;
    Res_Ready = 1'b1;
    @(posedge Clk); #1;
    Res_Ready = 1'b0;
`else
    g = 0;
    n = 0;
`endif

    repeat (4) @(posedge Clk);
    check("queues_drained", {32'(wq.size()), 32'(rq.size())}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sad_load_ctrl.md
# sad_load_ctrl

Sequencer for the SAD subsystem. Accepts a 32-bit word stream from the host, writes the first `WORDS` words into memory A and the next `WORDS` words into memory B through the 32-bit B-ports of the two dual-port SRAMs, then pulses `Go_t` to the SAD core. It waits for `Done_t`, then returns `SAD_Out_t` to the host over a valid/ready result channel. It sits between the host bus adapter and the SAD top level, and owns every SRAM port-B signal and both synchronous sub-block resets.

## Interface
- `WORDS`, 64: 32-bit words per memory image; legal range 1..64.
- `TIMEOUT`, 1023: cycles `WAIT` tolerates without `Done_t` (used only with `SAD_TIMEOUT_EN`); range 1..65535.

- `Clk` in 1: single clock; all logic is rising-edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `In_Data` in 32: load word.
- `In_Valid` in 1: load word present.
- `In_Ready` out 1: controller accepts the word this cycle.
- `Res_Data` out 32: captured SAD value.
- `Res_Err` out 1: result aborted by the timeout.
- `Res_Valid` out 1: result present.
- `Res_Ready` in 1: host takes the result.
- `MA_di31`, `MB_di31` out 32: port-B write data.
- `MA_Addr6`, `MB_Addr6` out 6: port-B address.
- `MA_enb`, `MB_enb`, `MA_web`, `MB_web` out 1: port-B enable and write enable.
- `Rst_M`, `Rst_Core` out 1: active-high synchronous resets to the SRAMs and the SAD core.
- `Go_t` out 1: SAD start.
- `Done_t` in 1: SAD finished.
- `SAD_Out_t` in 32: SAD result.
- `Busy` out 1: state is not `LOAD_A` with a count of 0.

## Operation
- States: `INIT`, `LOAD_A`, `LOAD_B`, `GO`, `WAIT`, `RESULT`. A 6-bit word counter `cnt` tracks the load position.
- `INIT`: entered on reset. Holds `Rst_M` and `Rst_Core` at 1 for 2 cycles after `Rst_n` deasserts, then moves to `LOAD_A` with `cnt` = 0.
- `LOAD_A` / `LOAD_B`: `In_Ready` = 1.
  - A handshake occurs when `In_Valid & In_Ready`.
  - On each handshake, the next cycle drives a one-cycle write: `MA_enb` = `MA_web` = 1, `MA_Addr6` = `cnt`, `MA_di31` = `In_Data`. `LOAD_B` does the same on the `MB_*` ports.
  - `cnt` increments on each handshake. On the handshake with `cnt` = `WORDS`-1, `cnt` returns to 0 and the state advances: `LOAD_A` goes to `LOAD_B`, `LOAD_B` goes to `GO`.
- `GO`: the final B write completes in this cycle. `Go_t` is registered high for exactly the following cycle, and the state moves to `WAIT`.
- `WAIT`: when `Done_t` is sampled high, `SAD_Out_t` is registered into `Res_Data`, `Res_Err` = 0, `Res_Valid` = 1, and the state moves to `RESULT`.
- `RESULT`: `Res_Data`, `Res_Err` and `Res_Valid` hold stable until `Res_Ready` = 1. On that cycle `Res_Valid` falls and the state moves to `LOAD_A`. `In_Ready` stays 0 until `LOAD_A` is entered.
- When no write is pending, SRAM port-B outputs are 0. Data and address outputs are registered and hold their last value.
- Reset mid-operation: the asynchronous `Rst_n` returns the block to `INIT` immediately. Any partial image is discarded and the host must restart from word 0.

## Timing
- Reset values: all outputs 0 except `Rst_M` = `Rst_Core` = 1 and `Busy` = 1.
- Handshake to SRAM write: 1 cycle. Sustained throughput is 1 word per cycle.
- Last B handshake at cycle t: B write at t+1, `Go_t` high at t+2 only.
- `Done_t` sampled at cycle d: `Res_Valid` = 1 at d+1.
- `Res_Ready` at cycle r: `In_Ready` = 1 at r+1.
- A `Done_t` pulse outside `WAIT` is ignored.
- `Done_t` and a timeout expiry in the same cycle: the `Done_t` result wins.
- A `Res_Ready` asserted before `Res_Valid` is ignored.

## Configuration
- Macro `SAD_TIMEOUT_EN`.
- Defined: a 16-bit watchdog clears on entry to `WAIT` and counts every `WAIT` cycle. When it reaches `TIMEOUT`, the block sets `Res_Valid` = 1, `Res_Err` = 1, `Res_Data` = 32'hFFFF_FFFF, and pulses `Rst_Core` for 1 cycle. The state moves to `RESULT`.
- Undefined: no watchdog is built. `WAIT` waits indefinitely and `Res_Err` is tied to 0.

## Test plan
- Reset release -> `Rst_M` and `Rst_Core` are high for exactly 2 cycles, then `In_Ready` = 1, with all write enables and `Go_t` at 0.
- 128 back-to-back words with values 0..127 (`WORDS` = 64) -> `MA_Addr6` runs 0..63 with data 0..63, `MB_Addr6` runs 0..63 with data 64..127, and `Go_t` is a 1-cycle pulse 2 cycles after the last handshake.
- `In_Valid` toggled randomly during the load -> no address skipped or repeated, and the write count equals the handshake count.
- `Done_t` with `SAD_Out_t` = 32'h0000_1A2B and `Res_Ready` held low for 5 cycles -> `Res_Data` stays 0x1A2B with `Res_Valid` = 1 throughout, and `In_Ready` rises the cycle after `Res_Ready`.
- `Rst_n` pulsed low at word 40 of A -> block returns to `INIT` and the next load writes starting at `MA_Addr6` = 0.
- With `SAD_TIMEOUT_EN` defined and `TIMEOUT` = 10, `Done_t` never asserted -> `Res_Err` = 1, `Res_Data` = 0xFFFFFFFF, and a 1-cycle `Rst_Core` pulse, all 10 cycles after entering `WAIT`.
